// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a 4:1 two-bit mux among four requesters with valid/ready output.
// Optional MUX_ARB_GRANT_CNT_EN adds an 8-bit grant counter port (grant_cnt).

module mux_rr_arbiter_mux4 (
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic [1:0] in3,
    input  logic [1:0] in4,
    input  logic       c1,
    input  logic       c2,
    output logic [1:0] y
);
    always_comb begin
        case ({c1, c2})
            2'b00:   y = in1;
            2'b01:   y = in2;
            2'b10:   y = in3;
            default: y = in4;
        endcase
    end
endmodule

module mux_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic [1:0] in3,
    input  logic [1:0] in4,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic       c1,
    output logic       c2,
    output logic       out_valid,
    output logic [1:0] out_data
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    output logic [7:0] grant_cnt
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       pick_vld;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       busy;
    logic       beat;
    logic       release_now;

    // Rotating priority: search ptr+1, ptr+2, ... wrapping back to ptr itself.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign busy      = (state_q == BUSY);
    assign out_valid = busy && req[sel_q];
    assign beat      = out_valid && out_ready;
    assign cnt_d     = cnt_q + CNT_W'(1);
    // Withdrawal releases without a beat; otherwise release on last or beat limit.
    assign release_now = busy && (!req[sel_q] ||
                         (beat && (last[sel_q] || (cnt_d == CNT_W'(MAX_BURST)))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= BUSY;
                        gnt_q   <= 4'b0001 << pick_idx;
                        sel_q   <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        ptr_q   <= sel_q;
                        cnt_q   <= '0;
                    end else if (beat) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                end
            endcase
        end
    end

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [7:0] gcnt_q;

    // Counts IDLE->BUSY transitions; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= 8'd0;
        end else if (!busy && pick_vld) begin
            gcnt_q <= gcnt_q + 8'd1;
        end
    end

    assign grant_cnt = gcnt_q;
`endif

    assign gnt = gnt_q;
    assign c1  = sel_q[1];
    assign c2  = sel_q[0];

    mux_rr_arbiter_mux4 u_mux (
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .c1  (c1),
        .c2  (c2),
        .y   (out_data)
    );
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios plus random traffic vs a behavioural model.
// Define MUX_ARB_GRANT_CNT_EN to also check grant_cnt.

module tb_mux_rr_arbiter;
    localparam int unsigned MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [1:0] in1, in2, in3, in4;
    logic       out_ready;
    logic [3:0] gnt;
    logic       c1, c2;
    logic       out_valid;
    logic [1:0] out_data;
`ifdef MUX_ARB_GRANT_CNT_EN
    logic [7:0] grant_cnt;
`endif

    mux_rr_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .out_ready (out_ready),
        .gnt       (gnt),
        .c1        (c1),
        .c2        (c2),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef MUX_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic [1:0] data;
        logic [7:0] gc;
    } exp_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] data;
    } beat_t;

    exp_t  st_q[$];
    beat_t beat_q[$];

    int total = 0;
    int bad   = 0;

    // Behavioural model: granted requester (-1 = idle), pointer, beats in burst, last select.
    int m_g, m_ptr, m_beats, m_sel, m_gc;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] in_of(input int i);
        case (i)
            0:       return in1;
            1:       return in2;
            2:       return in3;
            default: return in4;
        endcase
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = 3; m_beats = 0; m_sel = 0; m_gc = 0;
    endtask

    // Applies one rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        if (m_g < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (m_g < 0 && req[i]) begin
                    m_g = i; m_sel = i; m_beats = 0; m_gc = (m_gc + 1) % 256;
                end
            end
        end else if (!req[m_g]) begin
            m_ptr = m_g; m_g = -1;
        end else if (out_ready) begin
            m_beats++;
            if (last[m_g] || m_beats == MAXB) begin
                m_ptr = m_g; m_g = -1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t  e;
        beat_t b;
        e.gnt  = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
        e.sel  = 2'(m_sel);
        e.vld  = (m_g >= 0) && req[m_g];
        e.data = in_of(m_sel);
        e.gc   = 8'(m_gc);
        st_q.push_back(e);
        if (e.vld && out_ready) begin
            b.gnt  = e.gnt;
            b.data = e.data;
            beat_q.push_back(b);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy, input logic [7:0] d);
        @(posedge clk);
        model_edge();
        #1;
        req = r; last = l; out_ready = rdy;
        in1 = d[1:0]; in2 = d[3:2]; in3 = d[5:4]; in4 = d[7:6];
        push_exp();
    endtask

    // Monitor: per-cycle status plus accepted-beat scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                exp_t e;
                e = st_q.pop_front();
                check("gnt", 8'(gnt), 8'(e.gnt));
                check("sel", 8'({c1, c2}), 8'(e.sel));
                check("out_valid", 8'(out_valid), 8'(e.vld));
                check("out_data", 8'(out_data), 8'(e.data));
`ifdef MUX_ARB_GRANT_CNT_EN
                check("grant_cnt", grant_cnt, e.gc);
`endif
            end
            if (rst_n && out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 8'(gnt), 8'h00);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_gnt", 8'(gnt), 8'(b.gnt));
                    check("beat_data", 8'(out_data), 8'(b.data));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        model_reset();
        #3;
        check("rst_gnt", 8'(gnt), 8'h00);
        check("rst_sel", 8'({c1, c2}), 8'h00);
        check("rst_valid", 8'(out_valid), 8'h00);
        #9 rst_n = 1'b1;

        // Single beat with last
        step(4'b0001, 4'b0001, 1'b1, 8'b00_00_00_11);
        repeat (3) step(4'b0001, 4'b0001, 1'b1, 8'b00_00_00_11);
        repeat (2) step(4'b0000, 4'b0000, 1'b1, 8'h00);

        // All requesting, single-beat bursts rotate
        repeat (10) step(4'b1111, 4'b1111, 1'b1, 8'b11_10_01_00);
        repeat (2) step(4'b0000, 4'b0000, 1'b1, 8'h00);

        // Beat limit on requester 2
        repeat (12) step(4'b0100, 4'b0000, 1'b1, 8'b00_01_00_00);
        repeat (2) step(4'b0000, 4'b0000, 1'b1, 8'h00);

        // Stall on requester 1
        step(4'b0010, 4'b0000, 1'b0, 8'b00_00_10_00);
        repeat (3) step(4'b0010, 4'b0000, 1'b0, 8'b00_00_10_00);
        repeat (5) step(4'b0010, 4'b0000, 1'b1, 8'b00_00_10_00);
        repeat (2) step(4'b0000, 4'b0000, 1'b1, 8'h00);

        // Requester 3 withdraws while requester 0 waits
        repeat (2) step(4'b1000, 4'b0000, 1'b0, 8'b01_00_00_10);
        step(4'b1001, 4'b0000, 1'b0, 8'b01_00_00_10);
        repeat (4) step(4'b0001, 4'b0000, 1'b0, 8'b01_00_00_10);
        repeat (2) step(4'b0000, 4'b0000, 1'b1, 8'h00);

        // Asynchronous reset mid-burst
        repeat (3) step(4'b0100, 4'b0000, 1'b0, 8'b00_11_00_00);
        #5;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_gnt", 8'(gnt), 8'h00);
        check("midrst_sel", 8'({c1, c2}), 8'h00);
        check("midrst_valid", 8'(out_valid), 8'h00);
`ifdef MUX_ARB_GRANT_CNT_EN
        check("midrst_gcnt", grant_cnt, 8'h00);
`endif
        #1 rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r, l;
            logic       rdy;
            r   = 4'($urandom);
            l   = 4'($urandom) & 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, l, rdy, 8'($urandom));
        end

        repeat (2) step(4'b0000, 4'b0000, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("status_q_drained", 8'(st_q.size()), 8'h00);
        check("beat_q_drained", 8'(beat_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
